// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter stage with valid/ready fetch handshake.
// Selects sequential / branch / JAL / JALR targets, redirects misaligned
// targets to TRAP_VECTOR and counts retired instructions.
// Optional feature macro: RVC_EN (16-bit compressed instruction support).
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imm_shifted,
  input  logic [31:0] rs1_val,
  input  logic [31:0] jalr_imm,
  input  logic        br_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic        upd_c,
  input  logic        upd_valid,
  input  logic        pc_ready,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        misalign_err,
  output logic [31:0] bad_addr,
  output logic [31:0] instret
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    TRAP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   bad_q, bad_d;
  logic [XLEN-1:0]   instret_q, instret_d;
  logic              pc_valid_q, pc_valid_d;
  logic              misalign_q, misalign_d;

  logic [XLEN-1:0]   inc;
  logic [XLEN-1:0]   jalr_sum;
  logic [XLEN-1:0]   target;
  logic              is_seq;
  logic              misaligned;

  // Sequential increment: 2 for compressed instructions when supported, else 4
`ifdef RVC_EN
  assign inc = upd_c ? XLEN'(2) : XLEN'(4);
`else
  logic unused_upd_c;
  assign unused_upd_c = upd_c;
  assign inc = XLEN'(4);
`endif

  // Target selection with priority JALR > JAL > branch > sequential
  always_comb begin
    jalr_sum = rs1_val + jalr_imm;
    is_seq   = 1'b0;
    target   = pc_q + inc;
    if (jalr) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (jal || br_taken) begin
      target = pc_q + imm_shifted;
    end else begin
      is_seq = 1'b1;
    end
  end

  // Alignment check on redirected targets; halfword targets legal with RVC
`ifdef RVC_EN
  assign misaligned = ~is_seq & target[0];
`else
  assign misaligned = ~is_seq & (target[1] | target[0]);
`endif

  // State register and all output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      bad_q      <= '0;
      instret_q  <= '0;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bad_q      <= bad_d;
      instret_q  <= instret_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    bad_d      = bad_q;
    instret_d  = instret_q;
    pc_valid_d = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (pc_ready) state_d = EXEC;
      end
      EXEC: begin
        if (upd_valid) begin
          instret_d = instret_q + XLEN'(1);
          if (misaligned) begin
            bad_d   = target;
            pc_d    = TRAP_VECTOR;
            state_d = TRAP;
          end else begin
            pc_d    = target;
            state_d = REQ;
          end
        end
      end
      TRAP:    state_d = REQ;
      default: state_d = BOOT;
    endcase
    pc_valid_d = (state_d == REQ);
    misalign_d = (state_d == TRAP);
  end

  assign pc_out       = pc_q;
  assign pc_valid     = pc_valid_q;
  assign misalign_err = misalign_q;
  assign bad_addr     = bad_q;
  assign instret      = instret_q;

endmodule
